// File: rtl/mmio_pkg.sv
// Shared MMIO definitions for the single-cycle MIPS I/O space (addr[7] = 1).
package mmio_pkg;

  localparam logic [7:0] MMIO_LED       = 8'h80;
  localparam logic [7:0] MMIO_KEY_LEVEL = 8'h81;
  localparam logic [7:0] MMIO_KEY_EDGE  = 8'h82;
  localparam logic [7:0] MMIO_KEY_COUNT = 8'h83;
  localparam logic [7:0] MMIO_KEY_IE    = 8'h84;

  localparam int COUNT_W = 16;

  function automatic logic key_addr_hit(input logic [7:0] a);
    return (a >= MMIO_KEY_LEVEL) && (a <= MMIO_KEY_IE);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser on the raw active-low key, then a
// stable-level debouncer that emits a one-cycle press pulse on 0->1.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          sample;
  logic          accept;

  // Synchroniser holds the raw (active-low) level so reset reads as released.
  assign sample = ~sync_q[1];
  assign accept = (sample != stable) && (cnt_q == CNT_LAST);
  assign press  = accept & sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      if (sample == stable) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable <= sample;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_key_in.sv
// Push-button MMIO read port: debounced level, sticky press flags, press
// counter and maskable interrupt, read combinationally during a load.
module mmio_key_in
  import mmio_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [7:0]        addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              hit,
  output logic              irq
);

  logic [N_KEYS-1:0]  level;
  logic [N_KEYS-1:0]  press;
  logic [N_KEYS-1:0]  edge_q;
  logic [N_KEYS-1:0]  ie_q;
  logic [COUNT_W-1:0] count_q;
  logic               wr_edge;
  logic               wr_count;
  logic               wr_ie;
  logic               unused_wdata;

  assign unused_wdata = ^wdata[31:COUNT_W];

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[g]),
      .stable(level[g]),
      .press (press[g])
    );
  end

  assign hit      = key_addr_hit(addr);
  assign wr_edge  = wr_en && (addr == MMIO_KEY_EDGE);
  assign wr_count = wr_en && (addr == MMIO_KEY_COUNT);
  assign wr_ie    = wr_en && (addr == MMIO_KEY_IE);

  // A press landing on the same edge as a W1C keeps its flag; a COUNT load
  // on the same edge as a press discards that press from the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q  <= '0;
      count_q <= '0;
      ie_q    <= '0;
    end else begin
      if (wr_edge) edge_q <= (edge_q & ~wdata[N_KEYS-1:0]) | press;
      else         edge_q <= edge_q | press;

      if (wr_count)    count_q <= wdata[COUNT_W-1:0];
      else if (|press) count_q <= count_q + COUNT_W'(1);

      if (wr_ie) ie_q <= wdata[N_KEYS-1:0];
    end
  end

  assign irq = |(edge_q & ie_q);

  always_comb begin
    rdata = '0;
    if (rd_en && hit) begin
      case (addr)
        MMIO_KEY_LEVEL: rdata[N_KEYS-1:0]  = level;
        MMIO_KEY_EDGE:  rdata[N_KEYS-1:0]  = edge_q;
        MMIO_KEY_COUNT: rdata[COUNT_W-1:0] = count_q;
        MMIO_KEY_IE:    rdata[N_KEYS-1:0]  = ie_q;
        default:        rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_key_in.sv
// Scoreboard bench for mmio_key_in against a sliding-window key model.
module tb_mmio_key_in;
  import mmio_pkg::*;

  localparam int N = 4;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_n;
  logic [7:0]   addr;
  logic         rd_en, wr_en;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         hit, irq;

  always #5 clk = ~clk;

  mmio_key_in #(.N_KEYS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .addr(addr), .rd_en(rd_en),
    .wr_en(wr_en), .wdata(wdata), .rdata(rdata), .hit(hit), .irq(irq)
  );

  // reference model: raw pressed samples per edge, oldest first
  logic [N-1:0]  m_hist[$];
  logic [N-1:0]  m_level, m_edge, m_ie;
  logic [15:0]   m_count;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] rd;
    logic        h;
    logic        q;
  } exp_t;
  exp_t sb[$];

  int  n_cmp = 0;
  int  n_bad = 0;
  logic chk = 1'b0;

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < D + 2; i++) m_hist.push_back('0);
    m_level = '0; m_edge = '0; m_ie = '0; m_count = '0;
  endtask

  // A key takes level v once the D synchronised samples ending two edges
  // ago all equal v.
  task automatic model_tick();
    logic [N-1:0] press, clr;
    logic         v, same;
    press = '0;
    clr   = '0;
    m_hist.push_back(~key_n);
    void'(m_hist.pop_front());
    for (int i = 0; i < N; i++) begin
      v = m_hist[0][i];
      same = 1'b1;
      for (int j = 0; j < D; j++) if (m_hist[j][i] != v) same = 1'b0;
      if (same && v != m_level[i]) begin
        m_level[i] = v;
        if (v) press[i] = 1'b1;
      end
    end
    if (wr_en && addr == MMIO_KEY_EDGE) clr = wdata[N-1:0];
    if (wr_en && addr == MMIO_KEY_IE)   m_ie = wdata[N-1:0];
    m_edge = (m_edge & ~clr) | press;
    if (wr_en && addr == MMIO_KEY_COUNT) m_count = wdata[15:0];
    else if (press != 0)                 m_count = m_count + 16'd1;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_tick();
    #1;
  endtask

  function automatic logic [31:0] m_reg(input logic [7:0] a);
    case (a)
      MMIO_KEY_LEVEL: return 32'(m_level);
      MMIO_KEY_EDGE:  return 32'(m_edge);
      MMIO_KEY_COUNT: return 32'(m_count);
      MMIO_KEY_IE:    return 32'(m_ie);
      default:        return 32'h0;
    endcase
  endfunction

  task automatic issue(input logic [7:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd);
    exp_t e;
    addr = a; rd_en = rd; wr_en = wr; wdata = wd;
    e.a  = a;
    e.h  = (a >= 8'h81 && a <= 8'h84);
    e.rd = (rd && e.h) ? m_reg(a) : 32'h0;
    e.q  = |(m_edge & m_ie);
    sb.push_back(e);
    chk = 1'b1;
    step();
    chk = 1'b0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [7:0] a);
    issue(a, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    issue(a, 1'b0, 1'b1, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("rdata@%h", e.a), rdata, e.rd);
        check($sformatf("hit@%h", e.a), 32'(hit), 32'(e.h));
        check("irq", 32'(irq), 32'(e.q));
      end
    end
  end

  initial begin
    rst = 1'b1; key_n = '1; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(2);

    // reset mid-debounce with keys then released
    wr(MMIO_KEY_IE, 32'hF);
    key_n[0] = 1'b0;
    idle(8);
    key_n = '1;
    rst = 1'b1;
    model_reset();
    idle(2);
    rst = 1'b0;
    for (int a = 8'h80; a <= 8'h85; a++) rd(8'(a));
    idle(D + 4);
    for (int a = 8'h81; a <= 8'h84; a++) rd(8'(a));

    // clean press on key 1, watched across the latency boundary
    key_n[1] = 1'b0;
    for (int i = 0; i < D + 4; i++) rd(MMIO_KEY_LEVEL);
    rd(MMIO_KEY_EDGE); rd(MMIO_KEY_COUNT);
    key_n[1] = 1'b1;
    idle(D + 4);
    rd(MMIO_KEY_LEVEL); rd(MMIO_KEY_EDGE);

    // bounce on key 0, then held
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) key_n[0] = ~key_n[0];
      rd(MMIO_KEY_LEVEL);
    end
    key_n[0] = 1'b0;
    idle(D + 4);
    rd(MMIO_KEY_LEVEL); rd(MMIO_KEY_COUNT);
    key_n = '1;
    idle(D + 4);

    // interrupt, W1C with simultaneous read, irq drop
    wr(MMIO_KEY_IE, 32'h2);
    rd(MMIO_KEY_IE);
    issue(MMIO_KEY_EDGE, 1'b1, 1'b1, 32'h2);
    rd(MMIO_KEY_EDGE);
    wr(MMIO_KEY_EDGE, 32'hF);
    rd(MMIO_KEY_EDGE);

    // press on key 1 landing on the same edge as a W1C of bit 1
    wr(MMIO_KEY_EDGE, 32'h2);
    key_n[1] = 1'b0;
    idle(1);
    key_n[1] = 1'b1;
    idle(D + 4);
    key_n[1] = 1'b0;
    idle(D + 1);
    wr(MMIO_KEY_EDGE, 32'h2);
    rd(MMIO_KEY_EDGE); rd(MMIO_KEY_COUNT);
    key_n = '1;
    idle(D + 4);

    // same-edge COUNT load beats the press
    key_n[3] = 1'b0;
    idle(D + 1);
    wr(MMIO_KEY_COUNT, 32'h1234);
    rd(MMIO_KEY_COUNT);
    key_n = '1;
    idle(D + 4);

    // counter wrap
    wr(MMIO_KEY_COUNT, 32'hFFFF);
    rd(MMIO_KEY_COUNT);
    key_n[2] = 1'b0;
    idle(D + 4);
    rd(MMIO_KEY_COUNT);
    key_n = '1;
    idle(D + 4);

    // two keys in the same cycle count once
    wr(MMIO_KEY_EDGE, 32'hF);
    key_n = 4'b0110;
    idle(D + 4);
    rd(MMIO_KEY_COUNT); rd(MMIO_KEY_EDGE); rd(MMIO_KEY_LEVEL);
    key_n = '1;
    idle(D + 4);

    // read isolation
    issue(MMIO_KEY_EDGE, 1'b0, 1'b0, 32'h0);
    rd(8'h10);

    // randomized traffic
    for (int it = 0; it < 1500; it++) begin
      int op;
      if ($urandom_range(0, 24) == 0) key_n = 4'($urandom);
      op = $urandom_range(0, 7);
      case (op)
        0, 1, 2: step();
        3, 4:    rd(8'($urandom_range(8'h7F, 8'h86)));
        5:       wr(8'($urandom_range(8'h81, 8'h84)), $urandom);
        6:       issue(8'($urandom_range(8'h80, 8'h85)), 1'b1, 1'b1, $urandom);
        default: issue(8'($urandom), 1'($urandom), 1'b0, 32'h0);
      endcase
    end

    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
